sum_feeder: RTL and testbench
=============================

// Module: sum_feeder
// PURPOSE
//  Upstream stage of the serial summer. Buffers operand words written by a host, then on
//  command issues a one-cycle start with the operand count and streams exactly that many
//  words, one per cycle, aligned to the summer's CALC sampling. Waits for the summer's done
//  level before accepting the next command.
// PARAMETERS
//  DATA_W  8   operand width; matches the summer's data/n width
//  DEPTH   16  operand buffer entries; power of two, >= 2
//  CNT_W   $clog2(DEPTH+1)  width of the occupancy count (derived localparam)
// PORTS
//  clk_i       in   1       clock, rising edge
//  rst_ni      in   1       asynchronous active-low reset
//  wr_en_i     in   1       host pushes wr_data_i this cycle
//  wr_data_i   in   DATA_W  operand word
//  full_o      out  1       buffer holds DEPTH words
//  count_o     out  CNT_W   words currently buffered
//  ovf_o       out  1       1-cycle pulse: push dropped because buffer full
//  go_i        in   1       host command: sum the next n_i buffered words
//  n_i         in   DATA_W  operand count for this command
//  busy_o      out  1       command in progress (state != IDLE)
//  err_o       out  1       1-cycle pulse: go_i rejected (n_i > count_o)
//  start_o     out  1       to summer start_i; 1-cycle pulse
//  n_o         out  DATA_W  to summer n_i; latched count, stable from start_o to IDLE
//  data_o      out  DATA_W  to summer data_i; head word while streaming, else 0
//  data_vld_o  out  1       data_o carries an operand this cycle
//  done_i      in   1       from summer done_o; level
// BEHAVIOUR
//  Reset (async, rst_ni=0): state IDLE, buffer empty, all outputs 0 (count_o=0, n_o=0).
//   Reset mid-command abandons it; buffered words are discarded.
//  Buffer: FIFO order. Push when wr_en_i && !full; push while full drops the word and
//   pulses ovf_o. Push and pop in the same cycle is legal when not full; count unchanged.
//   The write is visible in count_o the next cycle.
//  FSM:
//   IDLE:   go_i && n_i <= count_o -> latch n_o=n_i, remaining=n_i, -> LAUNCH.
//           go_i && n_i > count_o  -> err_o pulse, stay IDLE, nothing popped.
//           go_i is ignored in all other states.
//   LAUNCH: start_o=1 for this one cycle. remaining==0 -> WAIT_DONE, else -> STREAM.
//   STREAM: data_vld_o=1, data_o=head, pop head, remaining-=1. remaining==1 -> WAIT_DONE.
//   WAIT_DONE: wait for done_i=1 -> IDLE. done_i is sampled only in this state.
//  Latency: go_i accepted in cycle T -> start_o in T+1 -> words 1..n on data_o in cycles
//   T+2..T+n+1, back to back with no gaps. The summer samples word k in its k-th CALC cycle.
//  n_i == 0: start_o still pulses, no words are streamed, and the block waits for done_i.
//  Width: remaining and n are DATA_W bits, unsigned. n_i > DEPTH always fails the count
//   check, so it is always rejected.
//  The host may keep pushing during STREAM and WAIT_DONE; the pop has priority for the
//   head, and pushed words queue behind the remaining operands.
// STRUCTURE
//  Package serial_pkg: DATA_W constant; feeder_state_e enum {IDLE, LAUNCH, STREAM,
//   WAIT_DONE} (logic [1:0]). Shared with the summer's state typedef.
//  Sub-module sync_fifo #(DATA_W, DEPTH): push/pop, full, empty, count, with an
//   asynchronous active-low reset. The feeder FSM, remaining counter, and error and
//   overflow pulses live in sum_feeder.
// TESTING
//  1. Push 3,5,7; go_i with n_i=3 -> start_o at T+1, n_o=3; data_o 3,5,7 in T+2..T+4 with
//     data_vld_o=1; summer sum_o=15; busy_o drops the cycle after done_i.
//  2. Push 2 words; go_i with n_i=4 -> err_o pulses once, count_o stays 2, no start_o.
//  3. Push 16 words, then push 1 more -> full_o=1, ovf_o pulses, count_o=16; stream n=16
//     -> 16 words in order; count_o=0 afterwards.
//  4. go_i with n_i=0 and an empty buffer -> start_o pulses, no data_vld_o; summer
//     done_o, sum_o=0; then IDLE.
//  5. Stream with n=4 and drop rst_ni during the 2nd word -> all outputs 0 at once,
//     count_o=0; after release, a new command works normally.
//  6. Push during STREAM (n=2 of 2 buffered, push 9) -> operands unchanged, count_o=1 at
//     the end.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the serial summer datapath.
//   DATA_W          operand / count width shared by the feeder and the summer
//   feeder_state_e  feeder FSM state encoding
package serial_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    STREAM    = 2'd2,
    WAIT_DONE = 2'd3
  } feeder_state_e;

endpackage : serial_pkg

// File: rtl/sync_fifo.sv
// Single-clock FIFO holding the operand words ahead of the summer.
// Ports:
//   clk_i    in   clock, rising edge
//   rst_ni   in   asynchronous active-low reset (empties the FIFO)
//   push_i   in   write wdata_i; ignored while full
//   pop_i    in   drop the head word; ignored while empty
//   wdata_i  in   word to write
//   rdata_o  out  current head word (meaningful only when not empty)
//   full_o   out  DEPTH words stored
//   empty_o  out  no words stored
//   count_o  out  number of words stored
module sync_fifo #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 16,
  localparam int CNT_W  = $clog2(DEPTH + 1),
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [CNT_W-1:0]  count_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              do_push, do_pop;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // NOTE: the storage array has no reset; resetting the pointers and count
  // already makes every old entry unreachable.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap by plain overflow.
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = cnt_q;

endmodule : sync_fifo

// File: rtl/sum_feeder.sv
// Upstream stage of the serial summer: buffers host operand words, then on
// go_i issues a one-cycle start with the operand count and streams exactly
// that many words back to back, then waits for the summer's done level.
// Ports:
//   clk_i, rst_ni         clock (rising edge), asynchronous active-low reset
//   wr_en_i, wr_data_i    host push of one operand word
//   full_o, count_o       buffer full / words buffered
//   ovf_o                 1-cycle pulse: push dropped because buffer was full
//   go_i, n_i             host command: sum the next n_i buffered words
//   busy_o                command in progress
//   err_o                 1-cycle pulse: command rejected (n_i > count_o)
//   start_o, n_o          to summer: start pulse and latched operand count
//   data_o, data_vld_o    to summer: operand word and its valid flag
//   done_i                from summer: done level
module sum_feeder #(
  parameter  int DATA_W = serial_pkg::DATA_W,
  parameter  int DEPTH  = 16,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              full_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              ovf_o,
  input  logic              go_i,
  input  logic [DATA_W-1:0] n_i,
  output logic              busy_o,
  output logic              err_o,
  output logic              start_o,
  output logic [DATA_W-1:0] n_o,
  output logic [DATA_W-1:0] data_o,
  output logic              data_vld_o,
  input  logic              done_i
);

  import serial_pkg::*;

  feeder_state_e     state_q, state_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] n_q, n_d;
  logic              err_q, err_d;
  logic              ovf_q, ovf_d;
  logic              too_many;
  logic              pop;
  logic [DATA_W-1:0] head;
  logic [CNT_W-1:0]  fifo_cnt;
  logic              fifo_full, fifo_empty;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (wr_en_i),
    .pop_i   (pop),
    .wdata_i (wr_data_i),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  // Compared at 32 bits so any n_i above DEPTH is rejected whatever the widths.
  assign too_many = 32'(n_i) > 32'(fifo_cnt);

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  // NOTE: every variable assigned in an always_comb gets a default first, so
  // no path through the block leaves it unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (go_i && !too_many) state_d = LAUNCH;
      LAUNCH:    state_d = (rem_q == '0) ? WAIT_DONE : STREAM;
      STREAM:    if (rem_q == DATA_W'(1)) state_d = WAIT_DONE;
      WAIT_DONE: if (done_i) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Outputs decoded from the current state
  always_comb begin
    start_o    = (state_q == LAUNCH);
    data_vld_o = (state_q == STREAM);
    busy_o     = (state_q != IDLE);
    pop        = (state_q == STREAM);
    data_o     = (state_q == STREAM) ? head : '0;
  end

  // Remaining counter, latched count and the error / overflow pulses
  always_comb begin
    rem_d = rem_q;
    n_d   = n_q;
    err_d = 1'b0;
    ovf_d = wr_en_i && fifo_full;
    if (state_q == IDLE && go_i) begin
      if (too_many) begin
        err_d = 1'b1;
      end else begin
        rem_d = n_i;
        n_d   = n_i;
      end
    end else if (state_q == STREAM) begin
      rem_d = rem_q - DATA_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rem_q <= '0;
      n_q   <= '0;
      err_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      rem_q <= rem_d;
      n_q   <= n_d;
      err_q <= err_d;
      ovf_q <= ovf_d;
    end
  end

  assign n_o     = n_q;
  assign err_o   = err_q;
  assign ovf_o   = ovf_q;
  assign full_o  = fifo_full;
  assign count_o = fifo_cnt;

  // fifo_empty is not needed here: a command never streams more words than
  // were buffered when it was accepted.
  logic unused_empty;
  assign unused_empty = fifo_empty;

endmodule : sum_feeder

// File: tb/tb_sum_feeder.sv
// Self-checking bench for sum_feeder. The reference is a word queue plus the
// transaction-level timing rules (accept, start one cycle later, n words back
// to back, then wait for done). The bench plays the summer: it sums the
// streamed words and drives done_i.
module tb_sum_feeder;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wr_en = 1'b0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              full;
  logic [CNT_W-1:0]  count;
  logic              ovf;
  logic              go = 1'b0;
  logic [DATA_W-1:0] n_in = '0;
  logic              busy;
  logic              err;
  logic              start;
  logic [DATA_W-1:0] n_out;
  logic [DATA_W-1:0] data;
  logic              vld;
  logic              done = 1'b0;

  always #5 clk = ~clk;

  sum_feeder #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .wr_en_i    (wr_en),
    .wr_data_i  (wr_data),
    .full_o     (full),
    .count_o    (count),
    .ovf_o      (ovf),
    .go_i       (go),
    .n_i        (n_in),
    .busy_o     (busy),
    .err_o      (err),
    .start_o    (start),
    .n_o        (n_out),
    .data_o     (data),
    .data_vld_o (vld),
    .done_i     (done)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [DATA_W-1:0] model_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_count"}, count, 0);
    check({tag, "_full"},  full,  0);
    check({tag, "_ovf"},   ovf,   0);
    check({tag, "_busy"},  busy,  0);
    check({tag, "_err"},   err,   0);
    check({tag, "_start"}, start, 0);
    check({tag, "_n_o"},   n_out, 0);
    check({tag, "_data"},  data,  0);
    check({tag, "_vld"},   vld,   0);
  endtask

  task automatic push(input logic [DATA_W-1:0] w);
    bit acc;
    acc = (model_q.size() < DEPTH);
    wr_en = 1'b1;
    wr_data = w;
    cyc();
    wr_en = 1'b0;
    if (acc) model_q.push_back(w);
    check("push_ovf",   ovf,   !acc);
    check("push_count", count, model_q.size());
    check("push_full",  full,  model_q.size() == DEPTH);
  endtask

  // Issue one command; optionally push extra word pw during the first stream
  // cycle. Returns the sum the summer would see.
  task automatic command(input int n, input bit do_push, input logic [DATA_W-1:0] pw,
                         input int dly, output int sum_obs);
    int sum_exp;
    bit acc;
    logic [DATA_W-1:0] exp_w;
    sum_obs = 0;
    sum_exp = 0;
    go = 1'b1;
    n_in = DATA_W'(n);
    cyc();
    go = 1'b0;
    if (n > model_q.size()) begin
      check("rej_err",   err,   1);
      check("rej_start", start, 0);
      check("rej_busy",  busy,  0);
      check("rej_count", count, model_q.size());
      cyc();
      check("rej_err_pulse", err,   0);
      check("rej_no_start",  start, 0);
      return;
    end
    check("launch_start", start, 1);
    check("launch_n_o",   n_out, n);
    check("launch_busy",  busy,  1);
    check("launch_vld",   vld,   0);
    check("launch_err",   err,   0);
    for (int k = 0; k < n; k++) begin
      cyc();
      wr_en = 1'b0;
      exp_w = model_q[0];
      check("stream_vld",   vld,   1);
      check("stream_data",  data,  exp_w);
      check("stream_start", start, 0);
      sum_obs += int'(data);
      sum_exp += int'(exp_w);
      acc = (model_q.size() < DEPTH);
      void'(model_q.pop_front());
      if (do_push && k == 0) begin
        if (acc) model_q.push_back(pw);
        wr_en = 1'b1;
        wr_data = pw;
      end
    end
    for (int d = 0; d < dly; d++) begin
      cyc();
      wr_en = 1'b0;
      check("wait_vld",  vld,  0);
      check("wait_data", data, 0);
      check("wait_busy", busy, 1);
    end
    done = 1'b1;
    cyc();
    done = 1'b0;
    check("idle_busy",  busy,  0);
    check("idle_count", count, model_q.size());
    check("sum",        sum_obs, sum_exp);
  endtask

  initial begin
    int s;
    // Reset state
    cyc();
    check_all_zero("reset");
    rst_n = 1'b1;
    cyc();

    // 1: three words summed in order
    push(8'd3); push(8'd5); push(8'd7);
    command(3, 1'b0, 8'd0, 2, s);
    check("t1_sum15", s, 15);

    // 2: count check rejects the command
    push(8'd11); push(8'd12);
    command(4, 1'b0, 8'd0, 1, s);
    command(2, 1'b0, 8'd0, 1, s);

    // 3: fill, overflow, stream all sixteen
    for (int i = 0; i < DEPTH; i++) push(DATA_W'($urandom));
    push(8'hAA);
    cyc();
    check("t3_ovf_pulse", ovf, 0);
    check("t3_count16",   count, 16);
    command(20, 1'b0, 8'd0, 1, s);
    command(16, 1'b0, 8'd0, 1, s);
    check("t3_count0", count, 0);

    // 4: zero-length command on an empty buffer
    command(0, 1'b0, 8'd0, 3, s);
    check("t4_sum0", s, 0);

    // 5: reset during the second streamed word
    for (int i = 0; i < 4; i++) push(DATA_W'(i + 40));
    go = 1'b1; n_in = 8'd4;
    cyc(); go = 1'b0;
    cyc();
    cyc();
    check("t5_word2", data, 41);
    rst_n = 1'b0;
    #1;
    check_all_zero("t5_async");
    model_q.delete();
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
    push(8'd1); push(8'd2);
    command(2, 1'b0, 8'd0, 1, s);
    check("t5_after_sum", s, 3);

    // 6: push while streaming queues behind the operands
    push(8'd20); push(8'd30);
    command(2, 1'b1, 8'd9, 2, s);
    check("t6_sum", s, 50);
    check("t6_count1", count, 1);
    command(1, 1'b0, 8'd0, 1, s);
    check("t6_pushed_word", s, 9);

    // Random mix of pushes and commands
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        int n;
        n = ($urandom_range(0, 7) == 0) ? int'($urandom_range(17, 255))
                                        : int'($urandom_range(0, model_q.size() + 2));
        command(n, ($urandom_range(0, 1) == 1) && n > 0, DATA_W'($urandom),
                int'($urandom_range(1, 4)), s);
      end else begin
        int b;
        b = int'($urandom_range(1, 6));
        for (int j = 0; j < b; j++) push(DATA_W'($urandom));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_sum_feeder
